// File: rtl/rv32_pkg.sv
// Shared RV32 memory-op encodings, LSU state type and op classification helpers.
package rv32_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_FLW   = 7'b0000111;
    localparam logic [6:0] OP_FSW   = 7'b0100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_t;

    // True when the opcode/funct3 pair names a supported memory access.
    function automatic logic op_legal(input logic [6:0] opcode, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (opcode)
            OP_LOAD:  ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                           (funct3 == F3_BU) || (funct3 == F3_HU);
            OP_STORE: ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
            OP_FLW:   ok = (funct3 == F3_W);
            OP_FSW:   ok = (funct3 == F3_W);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic op_is_store(input logic [6:0] opcode);
        return (opcode == OP_STORE) || (opcode == OP_FSW);
    endfunction

    // Halfwords need even addresses, words need 4-byte alignment.
    function automatic logic op_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store strobes/replication and load extraction with extension.
module lsu_lane_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Select the addressed byte/half of the read word.
    always_comb begin
        rbyte = rdata_i[{addr_lo_i, 3'b000} +: 8];
        rhalf = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    end

    // Store side: replicate the datum across all lanes and enable only the addressed ones.
    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load side: sign- or zero-extend the extracted field.
    always_comb begin
        rdata_o = rdata_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{rbyte[7]}}, rbyte};
            F3_BU:   rdata_o = {24'h0, rbyte};
            F3_H:    rdata_o = {{16{rhalf[15]}}, rhalf};
            F3_HU:   rdata_o = {16'h0, rhalf};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time, runs a req/gnt/rvalid transaction and
// returns a single completion pulse with extended load data or an error/misaligned status.
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_misaligned,
    output logic        out_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_t state_q, state_d;

    logic [6:0]      op_q, op_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_q, data_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            mis_q, mis_d;

    logic            in_legal;
    logic            in_mis;
    logic            st_q;
    logic [3:0]      lane_wstrb;
    logic [31:0]     lane_wdata;
    logic [31:0]     lane_rdata;

    lsu_lane_align u_lane_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .wstrb_o   (lane_wstrb),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

    // Classify the incoming op and the captured op.
    always_comb begin
        in_legal = op_legal(opcode, funct3);
        in_mis   = op_misaligned(funct3, addr[1:0]);
        st_q     = op_is_store(op_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = (!in_legal || in_mis) ? StDone : StReq;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    state_d = st_q ? StDone : StWait;
                end
            end
            StWait: begin
                if (mem_rvalid || (cnt_q == CntLast)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Capture registers, timeout counter and completion status.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            op_q    <= op_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    // Datapath next-state: capture in IDLE, count in WAIT, clear status leaving DONE.
    always_comb begin
        op_d    = op_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mis_d   = mis_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = opcode;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    data_d  = '0;
                    // Illegal takes precedence so misaligned is only flagged for real ops.
                    err_d   = !in_legal;
                    mis_d   = in_legal && in_mis;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    cnt_d = '0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    data_d = lane_rdata;
                end else if (cnt_q == CntLast) begin
                    data_d = '0;
                    err_d  = 1'b1;
                end
            end
            StDone: begin
                data_d = '0;
                err_d  = 1'b0;
                mis_d  = 1'b0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Outputs decode purely from registered state and captured fields.
    always_comb begin
        in_ready       = (state_q == StIdle);
        mem_req        = (state_q == StReq);
        mem_we         = (state_q == StReq) && st_q;
        mem_addr       = (state_q == StReq) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wdata      = ((state_q == StReq) && st_q) ? lane_wdata : 32'h0;
        mem_wstrb      = ((state_q == StReq) && st_q) ? lane_wstrb : 4'h0;
        out_valid      = (state_q == StDone);
        out_data       = (state_q == StDone) ? data_q : 32'h0;
        out_err        = (state_q == StDone) && err_q;
        out_misaligned = (state_q == StDone) && mis_q;
    end

endmodule
